inst_queue: RTL and testbench
=============================

# inst_queue

Show-ahead instruction FIFO between the fetch unit and the decode stage. It buffers {instruction, PC} pairs pushed by fetch and presents the oldest pair combinationally, so decode can inspect it and pop it in the same cycle. It exposes an almost-full flag so fetch stops early enough to absorb in-flight fetches. It is flushed on ROB-signalled misprediction.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries; power of two, at least 4.
- `PTR_W`, default 4: log2(`DEPTH`).
- `FULL_MARGIN`, default 2: number of free slots reserved for in-flight fetches; must be less than `DEPTH`.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `rdy` input 1: global ready; when low, all state holds.
- `clear` input 1: flush from ROB (misprediction).
- `IF_valid` input 1: push request.
- `IF_inst` input `InstBus` (32): instruction to push.
- `IF_pc` input `AddressBus` (32): PC of the pushed instruction.
- `IF_queue_is_full` output 1: almost-full flag to fetch.
- `queue_is_empty` output 1: equals `IQEmpty` when `count` is 0.
- `inst` output 32: head instruction.
- `pc` output 32: head PC.
- `ID_enable` input 1: pop request from decode.
- `count` output `PTR_W`+1: current occupancy, 0 to `DEPTH`.
- `overflow` output 1: sticky error flag.

## Operation
- Storage is a `DEPTH`-entry circular buffer with `head` and `tail` pointers of `PTR_W` bits. Both wrap modulo `DEPTH` by natural overflow. `count` is a separate `PTR_W`+1 bit register.
- Push accepted: `rdy` && !`clear` && `IF_valid` && `count` < `DEPTH`. The entry is written at `tail`, and `tail` increments.
- Push with `count` == `DEPTH`:
  - The push is dropped and `overflow` is set.
  - `overflow` clears only on reset. A correct fetch never causes this; verification treats it as a failure.
- Pop accepted: `rdy` && !`clear` && `ID_enable` && `count` != 0. `head` increments. Pop while empty is ignored and raises no error.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both or neither occur.
- Push and pop in the same cycle:
  - Legal at any occupancy below `DEPTH`.
  - At `DEPTH`, the push is rejected (fullness is judged on registered `count`) and the pop proceeds.
- Clear (with `rdy` high):
  - `head`, `tail` and `count` go to 0.
  - The same-cycle push and pop are discarded.
  - Array contents are not scrubbed.
- `rdy` low: no pointer, count or array change, including on `clear`. Reset is applied regardless of `rdy`.
- Head outputs:
  - `inst` = mem[`head`] and `pc` = pcmem[`head`] when `count` != 0.
  - Both are forced to 0 when empty.
  - This is a combinational read of registered state only; there is no path from `IF_*` to `inst`/`pc`.
- `IF_queue_is_full` = (`count` >= `DEPTH` − `FULL_MARGIN`), from registered `count`.
- `queue_is_empty` = `IQEmpty` when `count` == 0, otherwise `IQNotEmpty`.

## Timing
- Reset values: `count`=0, `head`=0, `tail`=0, `queue_is_empty`=`IQEmpty`, `IF_queue_is_full`=0, `inst`=0, `pc`=0, `overflow`=0.
- Push at cycle N: the entry is visible at the head no earlier than cycle N+1. Push-to-head latency on an empty queue is exactly 1 cycle.
- Pop at cycle N: the next entry (or empty) is presented in cycle N+1.
- Decode samples `inst`/`pc` and drives `ID_enable` within the same cycle, so `ID_enable` may depend combinationally on `inst`. The block must not feed `ID_enable` back into `inst`, `pc` or `queue_is_empty` in that cycle.
- Clear at cycle N: `queue_is_empty`=`IQEmpty` from N+1. A push at N+1 is accepted normally.
- All flags are registered-state derived, with no combinational input-to-flag paths. Throughput is 1 push and 1 pop per cycle sustained.

## Structure
- Shared header `cpu_define.v`:
  - `InstBus`, `AddressBus`.
  - `IQEmpty` (1'b1) and `IQNotEmpty` (1'b0).
  - `Enable`/`Disable` and `Valid`/`Invalid` constants used on the `IF_valid` and `ID_enable` handshakes.
- A single module with no sub-module. The two storage arrays (inst, pc) are plain register arrays in the block, and the pointer/count logic lives in one clocked process.

## Test plan
- Reset, then 3 pushes (pc 0x0, 0x4, 0x8; inst 0x00000013) with no pops → `count`=3, head `pc`=0x0. Three single-cycle pops present 0x4, 0x8, then `queue_is_empty`=`IQEmpty` with `inst`=0.
- Fill from empty with no pops (`DEPTH`=16, `FULL_MARGIN`=2):
  - `IF_queue_is_full` rises the cycle after the 14th push.
  - A 17th push with `count`=16 → dropped, `overflow`=1, `count` stays 16.
- Simultaneous push+pop every cycle for 40 cycles starting at `count`=5 → `count` constant at 5, pointers wrap at least twice, PC order preserved.
- `count`=7 with `clear` and `IF_valid` asserted together → next cycle `count`=0, empty. A push of pc 0x100 the following cycle → head `pc`=0x100 one cycle later.
- `rdy` low for 3 cycles with `IF_valid`, `ID_enable` and `clear` all asserted → `count`, head and outputs unchanged. When `rdy` returns high, normal behaviour resumes.
- Reset asserted (`rst`=0) mid-stream at `count`=9 with `rdy` low → next cycle all outputs at reset values.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared bus types and handshake/status encodings for the fetch-to-decode
// instruction queue.
package inst_queue_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [INST_W-1:0] inst_bus_t;
    typedef logic [ADDR_W-1:0] addr_bus_t;

    localparam logic IQ_EMPTY     = 1'b1;
    localparam logic IQ_NOT_EMPTY = 1'b0;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

endpackage

// File: rtl/inst_queue.sv
// Show-ahead {instruction, PC} FIFO between fetch and decode. The head entry
// is presented combinationally from registered state so decode can pop it
// in the same cycle it inspects it.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             IF_valid,
    input  inst_bus_t        IF_inst,
    input  addr_bus_t        IF_pc,
    output logic             IF_queue_is_full,
    output logic             queue_is_empty,
    output inst_bus_t        inst,
    output addr_bus_t        pc,
    input  logic             ID_enable,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] DEPTH_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH - FULL_MARGIN);

    inst_bus_t inst_mem [DEPTH];
    addr_bus_t pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             overflow_reg;

    logic live;
    logic push_ok;
    logic push_drop;
    logic pop_ok;
    logic not_empty;

    assign live      = rdy && !clear;
    assign not_empty = (count_reg != '0);
    assign push_ok   = live && (IF_valid == VALID) && (count_reg < DEPTH_CNT);
    assign push_drop = live && (IF_valid == VALID) && (count_reg == DEPTH_CNT);
    assign pop_ok    = live && (ID_enable == ENABLE) && not_empty;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + 1'b1;
        else if (pop_ok && !push_ok)
            count_next = count_reg - 1'b1;
    end

    // Pointer/count/error state; rdy low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (rdy) begin
            if (clear) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push_ok)
                    tail_reg <= tail_reg + 1'b1;
                if (pop_ok)
                    head_reg <= head_reg + 1'b1;
                count_reg <= count_next;
                if (push_drop)
                    overflow_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            inst_mem[tail_reg] <= IF_inst;
            pc_mem[tail_reg]   <= IF_pc;
        end
    end

    assign inst             = not_empty ? inst_mem[head_reg] : '0;
    assign pc               = not_empty ? pc_mem[head_reg]   : '0;
    assign queue_is_empty   = not_empty ? IQ_NOT_EMPTY : IQ_EMPTY;
    assign IF_queue_is_full = (count_reg >= FULL_LEVEL);
    assign count            = count_reg;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_inst_queue.sv
// Directed-vector bench for inst_queue with hand-computed expectations.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        IF_valid;
    inst_bus_t   IF_inst;
    addr_bus_t   IF_pc;
    logic        IF_queue_is_full;
    logic        queue_is_empty;
    inst_bus_t   inst;
    addr_bus_t   pc;
    logic        ID_enable;
    logic [4:0]  count;
    logic        overflow;

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    inst_queue #(.DEPTH(16), .PTR_W(4), .FULL_MARGIN(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .clear            (clear),
        .IF_valid         (IF_valid),
        .IF_inst          (IF_inst),
        .IF_pc            (IF_pc),
        .IF_queue_is_full (IF_queue_is_full),
        .queue_is_empty   (queue_is_empty),
        .inst             (inst),
        .pc               (pc),
        .ID_enable        (ID_enable),
        .count            (count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vec_cnt++;
        if (observed !== expected) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        IF_valid = INVALID; IF_inst = '0; IF_pc = '0; ID_enable = DISABLE;
        tick(); tick();
        rst = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(queue_is_empty), 32'(IQ_EMPTY));
        check("rst_full",  32'(IF_queue_is_full), 32'd0);
        check("rst_inst",  inst, 32'd0);
        check("rst_pc",    pc, 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);

        // Three pushes, no pops
        for (int i = 0; i < 3; i++) begin
            IF_valid = VALID; IF_inst = 32'h0000_0013; IF_pc = 32'(4 * i);
            tick();
            if (i == 0) check("push_lat1_pc", pc, 32'h0);
        end
        IF_valid = INVALID;
        check("p3_count", 32'(count), 32'd3);
        check("p3_pc",    pc, 32'h0);
        check("p3_inst",  inst, 32'h0000_0013);

        ID_enable = ENABLE;
        tick(); check("pop1_pc", pc, 32'h4);
        tick(); check("pop2_pc", pc, 32'h8);
        tick();
        check("pop3_empty", 32'(queue_is_empty), 32'(IQ_EMPTY));
        check("pop3_inst",  inst, 32'd0);
        check("pop3_count", 32'(count), 32'd0);
        tick();
        check("pop_empty_count", 32'(count), 32'd0);
        ID_enable = DISABLE;

        // Fill to DEPTH; almost-full rises after the 14th push
        for (int i = 0; i < 16; i++) begin
            IF_valid = VALID; IF_inst = 32'(i); IF_pc = 32'h1000 + 32'(4 * i);
            tick();
            check($sformatf("fill%0d_full", i + 1), 32'(IF_queue_is_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
        end
        IF_pc = 32'h1F00;
        tick();
        IF_valid = INVALID;
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_head",  pc, 32'h1000);

        // Drain to 5 entries
        ID_enable = ENABLE;
        for (int i = 0; i < 11; i++) tick();
        ID_enable = DISABLE;
        check("drain_count", 32'(count), 32'd5);
        check("drain_pc",    pc, 32'h102C);
        check("drain_full",  32'(IF_queue_is_full), 32'd0);

        // 40 cycles of simultaneous push+pop at count 5
        for (int k = 0; k < 40; k++) begin
            IF_valid = VALID; ID_enable = ENABLE;
            IF_pc = 32'h2000 + 32'(4 * k); IF_inst = 32'hA000_0000 + 32'(k);
            tick();
            check($sformatf("pp%0d_count", k), 32'(count), 32'd5);
            check($sformatf("pp%0d_pc", k), pc,
                  (k + 1 < 5) ? 32'h102C + 32'(4 * (k + 1)) : 32'h2000 + 32'(4 * (k + 1 - 5)));
        end
        ID_enable = DISABLE;
        check("pp_inst", inst, 32'hA000_0023);

        // Bring to 7, then clear with push and pop asserted
        IF_pc = 32'h3000; tick();
        IF_pc = 32'h3004; tick();
        check("pre_clr_count", 32'(count), 32'd7);
        clear = 1'b1; IF_valid = VALID; ID_enable = ENABLE; IF_pc = 32'h3008;
        tick();
        clear = 1'b0; ID_enable = DISABLE;
        check("clr_count", 32'(count), 32'd0);
        check("clr_empty", 32'(queue_is_empty), 32'(IQ_EMPTY));
        check("clr_pc",    pc, 32'd0);
        IF_valid = VALID; IF_pc = 32'h100; IF_inst = 32'hABCD_0001;
        tick();
        IF_valid = INVALID;
        check("post_clr_pc",    pc, 32'h100);
        check("post_clr_count", 32'(count), 32'd1);

        // rdy low freezes everything, including clear
        rdy = 1'b0; IF_valid = VALID; ID_enable = ENABLE; clear = 1'b1; IF_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_count", i), 32'(count), 32'd1);
            check($sformatf("hold%0d_pc", i), pc, 32'h100);
            check($sformatf("hold%0d_inst", i), inst, 32'hABCD_0001);
            check($sformatf("hold%0d_empty", i), 32'(queue_is_empty), 32'(IQ_NOT_EMPTY));
        end
        rdy = 1'b1; clear = 1'b0; ID_enable = DISABLE; IF_pc = 32'h104; IF_inst = 32'hABCD_0002;
        tick();
        IF_valid = INVALID;
        check("resume_count", 32'(count), 32'd2);
        check("resume_pc",    pc, 32'h100);
        ID_enable = ENABLE;
        tick();
        ID_enable = DISABLE;
        check("resume_pop_pc",   pc, 32'h104);
        check("resume_pop_inst", inst, 32'hABCD_0002);

        // Grow to 9, then reset with rdy low
        for (int i = 0; i < 8; i++) begin
            IF_valid = VALID; IF_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        IF_valid = INVALID;
        check("pre_rst_count", 32'(count), 32'd9);
        check("pre_rst_ovf",   32'(overflow), 32'd1);
        rdy = 1'b0; rst = 1'b0; IF_valid = VALID; ID_enable = ENABLE;
        tick();
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_empty", 32'(queue_is_empty), 32'(IQ_EMPTY));
        check("mrst_full",  32'(IF_queue_is_full), 32'd0);
        check("mrst_inst",  inst, 32'd0);
        check("mrst_pc",    pc, 32'd0);
        check("mrst_ovf",   32'(overflow), 32'd0);
        rst = 1'b1; rdy = 1'b1; IF_valid = INVALID; ID_enable = DISABLE;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
